// File: rtl/tb_cmd_sched_pkg.sv
// Shared types and default sizing for the alias command scheduler.
// Enum encodings match the command and status codes seen on the ports.
package tb_cmd_sched_pkg;

  localparam int REQ_NB_DEF    = 4;
  localparam int ALIAS_NB_DEF  = 5;
  localparam int WIDTH_DEF     = 32;
  localparam int TIMEOUT_W_DEF = 16;

  typedef enum logic [1:0] {
    CMD_SET   = 2'd0,
    CMD_WAIT  = 2'd1,
    CMD_CHECK = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_TIMEOUT    = 2'd1,
    ST_CHECK_FAIL = 2'd2,
    ST_ERR        = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tb_cmd_sched_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting after the last accepted
// winner; the pointer only advances when the caller accepts the grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N-1:0]                          i_req,
  input  logic                                  i_accept,
  output logic [N-1:0]                          o_grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  o_idx
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;

  always_comb begin : rr_search
    logic             found;
    logic [IDX_W-1:0] cand;
    found   = 1'b0;
    cand    = '0;
    o_grant = '0;
    o_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last_q) + i) % N);
      if (!found && i_req[cand]) begin
        found          = 1'b1;
        o_grant[cand]  = 1'b1;
        o_idx          = cand;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (i_accept) begin
      last_d = o_idx;
    end
  end

  // Pointer resets to the last requester so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tb_cmd_sched.sv
// Command scheduler: arbitrates SET/WAIT/CHECK commands from several
// requesters onto shared alias slots, one command at a time.
module tb_cmd_sched
  import tb_cmd_sched_pkg::*;
#(
  parameter int REQ_NB    = REQ_NB_DEF,
  parameter int ALIAS_NB  = ALIAS_NB_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REQ_NB-1:0]                    i_req,
  input  logic [REQ_NB-1:0][1:0]               i_cmd,
  input  logic [REQ_NB-1:0][2:0]               i_alias_idx,
  input  logic [REQ_NB-1:0][WIDTH-1:0]         i_data,
  input  logic [REQ_NB-1:0][TIMEOUT_W-1:0]     i_timeout,
  input  logic [ALIAS_NB-1:0]                  i_wait,
  input  logic [ALIAS_NB-1:0][WIDTH-1:0]       i_check,
  output logic [ALIAS_NB-1:0][WIDTH-1:0]       o_set,
  output logic [REQ_NB-1:0]                    o_ack,
  output logic [1:0]                           o_status,
  output logic                                 o_busy
);

  localparam int IDX_W = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;

  state_t                        state_q, state_d;
  cmd_t                          cmd_q, cmd_d;
  status_t                       status_q, status_d;
  logic [2:0]                    alias_q, alias_d;
  logic [WIDTH-1:0]              data_q, data_d;
  logic [TIMEOUT_W-1:0]          timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0]          counter_q, counter_d;
  logic [REQ_NB-1:0]             grant_q, grant_d;
  logic                          err_q, err_d;
  logic [ALIAS_NB-1:0]           prev_wait_q, prev_wait_d;
  logic [ALIAS_NB-1:0][WIDTH-1:0] set_q, set_d;

  logic [REQ_NB-1:0] arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_accept;
  logic [ALIAS_NB-1:0] wait_edge;

  rr_arbiter #(.N(REQ_NB)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_accept (arb_accept),
    .o_grant  (arb_grant),
    .o_idx    (arb_idx)
  );

  assign wait_edge = i_wait & ~prev_wait_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    status_d    = status_q;
    alias_d     = alias_q;
    data_d      = data_q;
    timeout_d   = timeout_q;
    counter_d   = counter_q;
    grant_d     = grant_q;
    err_d       = err_q;
    set_d       = set_q;
    prev_wait_d = i_wait;
    arb_accept  = 1'b0;

    case (state_q)
      S_IDLE: begin
        counter_d = '0;
        if (|i_req) begin
          arb_accept = 1'b1;
          grant_d    = arb_grant;
          cmd_d      = cmd_t'(i_cmd[arb_idx]);
          alias_d    = i_alias_idx[arb_idx];
          data_d     = i_data[arb_idx];
          timeout_d  = i_timeout[arb_idx];
          err_d      = (i_cmd[arb_idx] == 2'd3) ||
                       (int'(i_alias_idx[arb_idx]) >= ALIAS_NB);
          state_d    = S_EXEC;
        end
      end

      // Bad commands still pass through EXEC so grant spacing stays fixed.
      S_EXEC: begin
        if (err_q) begin
          status_d = ST_ERR;
          state_d  = S_DONE;
        end else begin
          case (cmd_q)
            CMD_SET: begin
              set_d[alias_q] = data_q;
              status_d       = ST_OK;
              state_d        = S_DONE;
            end
            CMD_CHECK: begin
              status_d = (i_check[alias_q] == data_q) ? ST_OK : ST_CHECK_FAIL;
              state_d  = S_DONE;
            end
            CMD_WAIT: begin
              if (wait_edge[alias_q]) begin
                status_d = ST_OK;
                state_d  = S_DONE;
              end else if ((timeout_q != '0) &&
                           (counter_q == timeout_q - TIMEOUT_W'(1))) begin
                status_d = ST_TIMEOUT;
                state_d  = S_DONE;
              end else begin
                counter_d = counter_q + TIMEOUT_W'(1);
              end
            end
            default: begin
              status_d = ST_ERR;
              state_d  = S_DONE;
            end
          endcase
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= CMD_SET;
      status_q    <= ST_OK;
      alias_q     <= '0;
      data_q      <= '0;
      timeout_q   <= '0;
      counter_q   <= '0;
      grant_q     <= '0;
      err_q       <= 1'b0;
      prev_wait_q <= '0;
      set_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      status_q    <= status_d;
      alias_q     <= alias_d;
      data_q      <= data_d;
      timeout_q   <= timeout_d;
      counter_q   <= counter_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      prev_wait_q <= prev_wait_d;
      set_q       <= set_d;
    end
  end

  assign o_set    = set_q;
  assign o_ack    = (state_q == S_DONE) ? grant_q : '0;
  assign o_status = (state_q == S_DONE) ? status_q : ST_OK;
  assign o_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_tb_cmd_sched.sv
// Scoreboard bench for tb_cmd_sched: directed commands push expected acks,
// an independent monitor pops and compares whenever an ack appears.
module tb_tb_cmd_sched;

  localparam int REQ_NB    = 4;
  localparam int ALIAS_NB  = 5;
  localparam int WIDTH     = 32;
  localparam int TIMEOUT_W = 16;

  localparam logic [1:0] C_SET   = 2'd0;
  localparam logic [1:0] C_WAIT  = 2'd1;
  localparam logic [1:0] C_CHECK = 2'd2;
  localparam logic [1:0] C_RSVD  = 2'd3;

  localparam logic [1:0] R_OK      = 2'd0;
  localparam logic [1:0] R_TIMEOUT = 2'd1;
  localparam logic [1:0] R_CHKBAD  = 2'd2;
  localparam logic [1:0] R_ERR     = 2'd3;

  logic                                  clk;
  logic                                  rst;
  logic [REQ_NB-1:0]                     i_req;
  logic [REQ_NB-1:0][1:0]                i_cmd;
  logic [REQ_NB-1:0][2:0]                i_alias_idx;
  logic [REQ_NB-1:0][WIDTH-1:0]          i_data;
  logic [REQ_NB-1:0][TIMEOUT_W-1:0]      i_timeout;
  logic [ALIAS_NB-1:0]                   i_wait;
  logic [ALIAS_NB-1:0][WIDTH-1:0]        i_check;
  logic [ALIAS_NB-1:0][WIDTH-1:0]        o_set;
  logic [REQ_NB-1:0]                     o_ack;
  logic [1:0]                            o_status;
  logic                                  o_busy;

  typedef struct {
    logic [REQ_NB-1:0]         ack;
    logic [1:0]                status;
    logic [ALIAS_NB*WIDTH-1:0] set;
  } exp_t;

  exp_t sb[$];
  logic [ALIAS_NB-1:0][WIDTH-1:0] exp_set;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  tb_cmd_sched #(
    .REQ_NB(REQ_NB), .ALIAS_NB(ALIAS_NB), .WIDTH(WIDTH), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_cmd       (i_cmd),
    .i_alias_idx (i_alias_idx),
    .i_data      (i_data),
    .i_timeout   (i_timeout),
    .i_wait      (i_wait),
    .i_check     (i_check),
    .o_set       (o_set),
    .o_ack       (o_ack),
    .o_status    (o_status),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [1:0] cmd, input logic [2:0] idx,
                               input logic [WIDTH-1:0] data, input logic [TIMEOUT_W-1:0] tmo);
    i_cmd[r]       = cmd;
    i_alias_idx[r] = idx;
    i_data[r]      = data;
    i_timeout[r]   = tmo;
    i_req[r]       = 1'b1;
  endtask

  task automatic pushExpect(input int r, input logic [1:0] st);
    exp_t e;
    e.ack    = '0;
    e.ack[r] = 1'b1;
    e.status = st;
    e.set    = exp_set;
    sb.push_back(e);
  endtask

  // Issue one command, optionally raise i_wait[idx] on EXEC cycle edgeCyc
  // (EXEC cycle 0 is the first sample after the grant), then wait for ack.
  task automatic runCmd(input int r, input logic [1:0] cmd, input logic [2:0] idx,
                        input logic [WIDTH-1:0] data, input logic [TIMEOUT_W-1:0] tmo,
                        input logic [1:0] st, input int edgeCyc, input int expLat);
    int lat;
    bit seen;
    if (cmd == C_SET && st == R_OK) exp_set[idx] = data;
    pushExpect(r, st);
    applyStimulus(r, cmd, idx, data, tmo);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (edgeCyc >= 0 && lat == edgeCyc + 1) i_wait[idx] = 1'b1;
      if (o_ack[r]) seen = 1;
    end
    i_req[r] = 1'b0;
    i_wait   = '0;
    checkOutput("ack_latency", lat, expLat);
    @(negedge clk);
  endtask

  // Monitor: every ack must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_ack !== '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", o_ack, '0);
        end else begin
          e = sb.pop_front();
          checkOutput("ack_vector", o_ack, e.ack);
          checkOutput("status", o_status, e.status);
          checkOutput("o_set", o_set, e.set);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackCyc[5];
    int n;
    int guard;
    rst = 1'b1;
    i_req = '0; i_cmd = '0; i_alias_idx = '0; i_data = '0; i_timeout = '0;
    i_wait = '0; i_check = '0;
    exp_set = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_ack", o_ack, 0);
    checkOutput("rst_status", o_status, 0);
    checkOutput("rst_set", o_set, 0);
    rst = 1'b0;
    @(negedge clk);

    runCmd(0, C_SET, 3'd2, 32'hCAFEDECA, 16'd0, R_OK, -1, 2);
    i_check[0] = 32'h12345678;
    runCmd(1, C_CHECK, 3'd0, 32'h12345678, 16'd0, R_OK, -1, 2);
    i_check[0] = 32'h12345679;
    runCmd(1, C_CHECK, 3'd0, 32'h12345678, 16'd0, R_CHKBAD, -1, 2);
    runCmd(2, C_SET, 3'd7, 32'hDEADBEEF, 16'd0, R_ERR, -1, 2);
    runCmd(3, C_RSVD, 3'd1, 32'h00000001, 16'd0, R_ERR, -1, 2);
    runCmd(0, C_SET, 3'd4, 32'h00005A5A, 16'd0, R_OK, -1, 2);

    runCmd(2, C_WAIT, 3'd1, 32'h0, 16'd10, R_OK, 4, 6);
    runCmd(2, C_WAIT, 3'd1, 32'h0, 16'd10, R_TIMEOUT, -1, 11);
    runCmd(3, C_WAIT, 3'd1, 32'h0, 16'd5, R_OK, 4, 6);

    // Reset in the middle of an endless WAIT aborts it without an ack.
    applyStimulus(1, C_WAIT, 3'd0, 32'h0, 16'd0);
    repeat (4) @(negedge clk);
    checkOutput("busy_in_wait", o_busy, 1);
    rst = 1'b1;
    i_req = '0;
    exp_set = '0;
    @(negedge clk);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_ack", o_ack, 0);
    checkOutput("abort_set", o_set, 0);
    rst = 1'b0;
    @(negedge clk);

    // All four requesters hold SET requests together.
    exp_set[0] = 32'hA0A0A0A0; pushExpect(0, R_OK);
    exp_set[1] = 32'hA1A1A1A1; pushExpect(1, R_OK);
    exp_set[3] = 32'hA3A3A3A3; pushExpect(2, R_OK);
    exp_set[4] = 32'hA4A4A4A4; pushExpect(3, R_OK);
    pushExpect(0, R_OK);
    applyStimulus(0, C_SET, 3'd0, 32'hA0A0A0A0, 16'd0);
    applyStimulus(1, C_SET, 3'd1, 32'hA1A1A1A1, 16'd0);
    applyStimulus(2, C_SET, 3'd3, 32'hA3A3A3A3, 16'd0);
    applyStimulus(3, C_SET, 3'd4, 32'hA4A4A4A4, 16'd0);
    n = 0;
    guard = 0;
    while (n < 5 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (o_ack !== '0) begin
        ackCyc[n] = cyc;
        n++;
      end
    end
    i_req = '0;
    checkOutput("rr_ack_count", n, 5);
    for (int i = 1; i < 5; i++) begin
      if (i < n) checkOutput("rr_spacing", ackCyc[i] - ackCyc[i-1], 3);
    end

    repeat (6) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("final_busy", o_busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
